// File: rtl/caliptra_prim_arbiter_pkg.sv
// Shared types and constants for the round-robin burst arbiter.
//   arb_state_e     : arbiter FSM state (idle = free to rotate, locked = grant held)
//   DefaultMaxBeats : default beat limit used when the burst limit is compiled in
package caliptra_prim_arbiter_pkg;

  typedef enum logic [0:0] {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  localparam int unsigned DefaultMaxBeats = 16;

endpackage

// File: rtl/caliptra_prim_arbiter_rr_burst_if.sv
// Bundle of the arbiter's request side and sink side.
//   req_i/data_i/last_i : per-requester valid, data and end-of-burst flag
//   ready_i             : sink ready
//   gnt_o/idx_o         : one-hot0 beat acceptance and current winner index
//   valid_o/data_o/last_o : beat presented to the sink
//   err_o               : one-cycle pulse when a burst was forcibly cut
// Modport slave is the arbiter's view; master is the environment's view.
interface caliptra_prim_arbiter_rr_burst_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]         req_i;
  logic [N-1:0][DW-1:0] data_i;
  logic [N-1:0]         last_i;
  logic                 ready_i;
  logic [N-1:0]         gnt_o;
  logic [IdxW-1:0]      idx_o;
  logic                 valid_o;
  logic [DW-1:0]        data_o;
  logic                 last_o;
  logic                 err_o;

  modport slave (
    input  req_i, data_i, last_i, ready_i,
    output gnt_o, idx_o, valid_o, data_o, last_o, err_o
  );

  modport master (
    output req_i, data_i, last_i, ready_i,
    input  gnt_o, idx_o, valid_o, data_o, last_o, err_o
  );
endinterface

// File: rtl/caliptra_prim_arbiter_fixed.sv
// Combinational fixed-priority pick: lowest set index of req_i wins.
//   req_i   : request vector
//   data_i  : per-requester data (only muxed when EnDataPort is set)
//   valid_o : any request present
//   idx_o   : index of the lowest set request (0 when none)
//   data_o  : winner's data, or 0 when EnDataPort is clear
module caliptra_prim_arbiter_fixed #(
  parameter int unsigned N          = 4,
  parameter int unsigned DW         = 32,
  parameter bit          EnDataPort = 1'b1,
  localparam int unsigned IdxW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0][DW-1:0] data_i,
  output logic                 valid_o,
  output logic [IdxW-1:0]      idx_o,
  output logic [DW-1:0]        data_o
);

  // seen[i] is set when some index below i is requesting, so first[] is one-hot0.
  logic [N:0]   seen;
  logic [N-1:0] first;

  assign seen[0] = 1'b0;
  for (genvar gi = 0; gi < N; gi++) begin : g_first
    assign first[gi]    = req_i[gi] & ~seen[gi];
    assign seen[gi + 1] = seen[gi] | req_i[gi];
  end

  assign valid_o = seen[N];

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (first[i]) idx_o = IdxW'(i);
    end
  end

  if (EnDataPort) begin : g_data
    assign data_o = data_i[idx_o];
  end else begin : g_no_data
    logic unused_data;
    assign unused_data = ^data_i;
    assign data_o      = '0;
  end

endmodule

// File: rtl/caliptra_prim_arbiter_rr_burst.sv
// N:1 round-robin arbiter with burst locking. A winner keeps the grant through
// stalled beats and multi-beat bursts until its last beat is accepted; the
// pointer then moves past it.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : request/sink bundle, see caliptra_prim_arbiter_rr_burst_if
// Optional feature macro CALIPTRA_PRIM_ARB_BURST_LIMIT_EN: caps a grant at
// MaxBeats accepted beats, forces re-arbitration and pulses err_o.
module caliptra_prim_arbiter_rr_burst
  import caliptra_prim_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned MaxBeats = DefaultMaxBeats,
  localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  caliptra_prim_arbiter_rr_burst_if.slave       bus
);

  if (N == 1) begin : g_single
    // A single requester never competes: pure pass-through.
    assign bus.valid_o  = bus.req_i[0];
    assign bus.gnt_o[0] = bus.req_i[0] & bus.ready_i;
    assign bus.idx_o    = '0;
    assign bus.data_o   = bus.data_i[0];
    assign bus.last_o   = bus.last_i[0];
    assign bus.err_o    = 1'b0;
  end else begin : g_multi
    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] winner, next_ptr, m_idx, r_idx;
    logic [N-1:0]    mask;
    logic            m_valid, r_valid, valid, xfer, last;
    logic [DW-1:0]   unused_m_data, unused_r_data;

    // Requests at or above the pointer get first pick; bits below it only win
    // when nothing at or above is requesting (wrap-around).
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (IdxW'(gi) >= ptr_q);
    end

    caliptra_prim_arbiter_fixed #(.N(N), .DW(DW), .EnDataPort(1'b0)) u_fixed_masked (
      .req_i   (bus.req_i & mask),
      .data_i  (bus.data_i),
      .valid_o (m_valid),
      .idx_o   (m_idx),
      .data_o  (unused_m_data)
    );

    caliptra_prim_arbiter_fixed #(.N(N), .DW(DW), .EnDataPort(1'b0)) u_fixed_raw (
      .req_i   (bus.req_i),
      .data_i  (bus.data_i),
      .valid_o (r_valid),
      .idx_o   (r_idx),
      .data_o  (unused_r_data)
    );

    // While locked, other requesters are invisible; a dropped request from the
    // locked port just idles the sink without releasing the lock.
    assign winner   = (state_q == ArbLocked) ? lock_idx_q : (m_valid ? m_idx : r_idx);
    assign valid    = (state_q == ArbLocked) ? bus.req_i[lock_idx_q] : r_valid;
    assign xfer     = valid & bus.ready_i;
    assign last     = bus.last_i[winner];
    assign next_ptr = (winner == IdxW'(N - 1)) ? '0 : winner + IdxW'(1);

    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
      assign bus.gnt_o[gi] = xfer & (winner == IdxW'(gi));
    end

    assign bus.valid_o = valid;
    assign bus.idx_o   = winner;
    assign bus.data_o  = bus.data_i[winner];
    assign bus.last_o  = last;

`ifdef CALIPTRA_PRIM_ARB_BURST_LIMIT_EN
    localparam int unsigned CntW = $clog2(MaxBeats + 1);
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      lock_idx_d = lock_idx_q;
`ifdef CALIPTRA_PRIM_ARB_BURST_LIMIT_EN
      beat_cnt_d = beat_cnt_q;
      err_d      = 1'b0;
`endif
      unique case (state_q)
        ArbIdle: begin
          if (valid) begin
            if (xfer && last) begin
              ptr_d = next_ptr;
            end else begin
              // Lock on a stalled beat too, so the presented beat stays stable.
              state_d    = ArbLocked;
              lock_idx_d = winner;
            end
          end
        end
        ArbLocked: begin
          if (xfer && last) begin
            state_d = ArbIdle;
            ptr_d   = next_ptr;
          end
        end
        default: state_d = ArbIdle;
      endcase
`ifdef CALIPTRA_PRIM_ARB_BURST_LIMIT_EN
      if (xfer) begin
        if (!last && (beat_cnt_q == CntW'(MaxBeats - 1))) begin
          // Limit reached mid-burst: cut the grant and rotate past the winner.
          state_d = ArbIdle;
          ptr_d   = next_ptr;
          err_d   = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
      end
      if (state_d == ArbIdle) beat_cnt_d = '0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= ArbIdle;
        ptr_q      <= '0;
        lock_idx_q <= '0;
      end else begin
        state_q    <= state_d;
        ptr_q      <= ptr_d;
        lock_idx_q <= lock_idx_d;
      end
    end

`ifdef CALIPTRA_PRIM_ARB_BURST_LIMIT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        beat_cnt_q <= '0;
        err_q      <= 1'b0;
      end else begin
        beat_cnt_q <= beat_cnt_d;
        err_q      <= err_d;
      end
    end
    assign bus.err_o = err_q;
`else
    logic unused_max_beats;
    assign unused_max_beats = ^32'(MaxBeats);
    assign bus.err_o        = 1'b0;
`endif

    LockedIdx: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == ArbLocked) |-> (bus.idx_o == lock_idx_q));
  end

  GntOnehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.gnt_o));
  GntNeedsReady: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|bus.gnt_o) |-> bus.ready_i);
  OutputsKnown: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({bus.valid_o, bus.gnt_o, bus.idx_o}));

endmodule

// File: tb/tb_caliptra_prim_arbiter_rr_burst.sv
module tb_caliptra_prim_arbiter_rr_burst;
  localparam int unsigned N        = 4;
  localparam int unsigned DW       = 32;
  localparam int unsigned MaxBeats = 4;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  caliptra_prim_arbiter_rr_burst_if #(.N(N), .DW(DW)) bus ();

  caliptra_prim_arbiter_rr_burst #(.N(N), .DW(DW), .MaxBeats(MaxBeats)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t left_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  function automatic logic [31:0] pattern(input int c, input int i);
    return 32'hA500_0000 | (32'(c) << 8) | 32'(i);
  endfunction

  // Drive one cycle of inputs; if a beat is expected, queue its full response.
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] last,
                      input logic rdy, input logic ev, input logic [3:0] eg,
                      input logic [1:0] ei, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst_ni      = rst;
    bus.req_i   = req;
    bus.last_i  = last;
    bus.ready_i = rdy;
    for (int i = 0; i < N; i++) bus.data_i[i] = pattern(cyc, i);
    if (ev) begin
      e.gnt  = eg;
      e.idx  = ei;
      e.data = pattern(cyc, int'(ei));
      e.last = last[ei];
      e.err  = ee;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: whenever a beat is presented, compare it with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.valid_o !== 1'b0) begin
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: valid_o=%b gnt_o=%b idx_o=%0d, required no beat", bus.valid_o, bus.gnt_o, bus.idx_o);
        end else begin
          mon_e = sb_q.pop_front();
          vectors++;
          if (bus.gnt_o !== mon_e.gnt || bus.idx_o !== mon_e.idx || bus.data_o !== mon_e.data ||
              bus.last_o !== mon_e.last || bus.err_o !== mon_e.err) begin
            miscompares++;
            $display("FAIL beat_%0d: got gnt=%b idx=%0d data=%h last=%b err=%b, required gnt=%b idx=%0d data=%h last=%b err=%b",
                     vectors, bus.gnt_o, bus.idx_o, bus.data_o, bus.last_o, bus.err_o,
                     mon_e.gnt, mon_e.idx, mon_e.data, mon_e.last, mon_e.err);
          end else begin
            $display("ok beat_%0d: gnt=%b idx=%0d data=%h last=%b err=%b",
                     vectors, bus.gnt_o, bus.idx_o, bus.data_o, bus.last_o, bus.err_o);
          end
        end
      end
    end
  end

  initial begin
    bus.req_i   = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;
    repeat (2) @(posedge clk);

    //   rst  req      last     rdy   ev    gnt      idx    err
    // Reset held: outputs are combinational from idle state, ptr 0.
    step(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    // Fairness, all single-beat.
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0);
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    // Pointer wrap: 3 granted (ptr -> 0), then 0 wins over 3 (ptr -> 1).
    step(1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0);
    step(1'b1, 4'b1001, 4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    // ptr 1: 3 beats 0 even though 0 is lower (ptr -> 0).
    step(1'b1, 4'b1001, 4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0);
    // Burst lock: requester 0 holds for 3 beats, then 1.
    step(1'b1, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b0011, 4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b0011, 4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);
    // Stall stability on requester 2, then accept.
    step(1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b0);
    step(1'b1, 4'b0101, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b0);
    step(1'b1, 4'b0101, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b0);
    step(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    // Locked requester 3 drops its request: no beat, lock holds.
    step(1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0);
    step(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    step(1'b1, 4'b1001, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0);
    // Reset mid-burst on requester 2.
    step(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    step(1'b0, 4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    // Long burst from requester 1 with requester 2 waiting.
    step(1'b1, 4'b0110, 4'b0100, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b0110, 4'b0100, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b0110, 4'b0100, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b0110, 4'b0100, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);
`ifdef CALIPTRA_PRIM_ARB_BURST_LIMIT_EN
    step(1'b1, 4'b0110, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
`else
    step(1'b1, 4'b0110, 4'b0100, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);
`endif
    step(1'b1, 4'b0110, 4'b0100, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b0110, 4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);

    @(posedge clk);
    #1;
    bus.req_i   = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    while (sb_q.size() != 0) begin
      left_e = sb_q.pop_front();
      miscompares++;
      $display("FAIL missing_beat: got no beat, required gnt=%b idx=%0d data=%h", left_e.gnt, left_e.idx, left_e.data);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/caliptra_prim_arbiter_rr_burst.md
# caliptra_prim_arbiter_rr_burst

N:1 round-robin arbiter with burst locking for shared valid/ready datapaths. Once a requester wins, its grant is held through a stalled beat or a multi-beat burst until the beat marked last is accepted. Arbitration then rotates to the next index. Sits in front of shared bus ports and crypto-engine inputs where fixed priority would starve low-index requesters.

## Interface
- N, 4, number of request ports (N ≥ 1)
- DW, 32, data width
- MaxBeats, 16, burst beat limit; used only when the burst limit feature is compiled in
- IdxW, localparam $clog2(N) (1 when N == 1), index width
- clk_i  input  1  clock
- rst_ni  input  1  reset; one clock, reset asynchronous and active-low
- req_i  input  N  per-requester valid
- data_i  input  DW×[N]  per-requester data
- last_i  input  N  per-requester end-of-burst flag
- gnt_o  output  N  one-hot0; beat accepted from requester i this cycle
- idx_o  output  IdxW  index of the current winner
- valid_o  output  1  beat presented to the sink
- data_o  output  DW  winner's data
- last_o  output  1  winner's last flag
- ready_i  input  1  sink ready
- err_o  output  1  one-cycle pulse: burst forcibly terminated

## Operation
- State encoding: ArbIdle and ArbLocked. Registers:
  - ptr: round-robin pointer, IdxW bits.
  - lock_idx: locked requester index.
  - beat_cnt: beat counter, present only with the feature macro.
- ArbIdle:
  - Winner is the lowest set index of req_i & ~((1<<ptr)-1).
  - If none is set, winner is the lowest set index of req_i.
  - valid_o = |req_i.
- ArbLocked:
  - Winner is lock_idx.
  - valid_o = req_i[lock_idx]. Requests from other ports are ignored.
- Outputs for the current winner:
  - idx_o = winner.
  - data_o = data_i[winner].
  - last_o = last_i[winner].
  - gnt_o[winner] = valid_o & ready_i. All other gnt_o bits are 0.
- Transitions, where xfer = valid_o & ready_i:
  - ArbIdle, valid_o & !ready_i → ArbLocked, lock_idx = winner. This holds a stalled beat stable.
  - ArbIdle, xfer & !last_o → ArbLocked, lock_idx = winner.
  - ArbIdle, xfer & last_o → stay ArbIdle, ptr = (winner+1) mod N.
  - ArbLocked, xfer & last_o → ArbIdle, ptr = (lock_idx+1) mod N.
  - ArbLocked, any other cycle → stay ArbLocked.
- Requester rules:
  - A requester must hold req_i until its last beat is accepted.
  - If the locked requester drops req_i, valid_o = 0 and the lock holds. This is not an error.
- ptr wrap: index N-1 → 0. ptr values ≥ N are unreachable.
- N == 1: no state machine. Outputs pass straight through. err_o = 0 and idx_o = 0.
- Reset values: state ArbIdle, ptr 0, lock_idx 0, beat_cnt 0, err_o 0.
- Combinational outputs after reset: valid_o = |req_i, gnt_o = 0 unless req and ready.
- Reset asserted mid-burst: the lock is dropped immediately and asynchronously, and the pending beat is lost.

## Timing
- req_i/ready_i → gnt_o/valid_o/idx_o/data_o is combinational, zero latency.
- State, ptr, lock_idx and beat_cnt update on the rising clk_i edge.
- Back-to-back single-beat grants to different requesters on consecutive cycles, with no idle cycle.
- err_o is registered: high for exactly the one cycle after the forcing beat.

## Configuration
- Macro: CALIPTRA_PRIM_ARB_BURST_LIMIT_EN.
- Defined:
  - beat_cnt (width $clog2(MaxBeats+1)) counts beats accepted in the current grant.
  - It clears on entry to ArbIdle.
  - On the MaxBeats-th accepted beat without last, the arbiter is forced to ArbIdle and ptr = winner+1.
  - err_o pulses on the next cycle.
  - Later beats from the same requester re-arbitrate as a new burst.
- Undefined: no counter, err_o tied to 0, bursts unbounded.

## Structure
- Package caliptra_prim_arbiter_pkg holds:
  - typedef enum logic [0:0] arb_state_e {ArbIdle, ArbLocked}.
  - The default MaxBeats constant.
- Sub-module: caliptra_prim_arbiter_fixed, instantiated twice.
  - One instance on the masked requests, one on the raw requests.
  - Both with EnDataPort=0.
  - Index and data muxing is done locally from the winner.
- Assertions:
  - gnt_o is onehot0.
  - gnt_o implies ready_i.
  - ArbLocked implies idx_o == lock_idx.
  - Known values on valid_o, gnt_o and idx_o.

## Test plan
- All single-beat, fairness: N=4, req_i=4'b1111, last_i=4'b1111, ready_i=1 for 5 cycles → gnt_o 0001, 0010, 0100, 1000, 0001.
- Burst lock: req_i=4'b0011, requester 0 has last on its 3rd beat, ready_i=1 → gnt_o=0001 for 3 cycles, then 0010.
- Stall stability: req_i=4'b0100 with ready_i=0, then req_i=4'b0101 for 2 cycles → idx_o stays 2. When ready_i=1, gnt_o=0100.
- Pointer wrap: requester 3 granted single-beat (ptr=0), then req_i=4'b1001 → gnt_o=0001, ptr=1.
- Burst limit, macro defined: MaxBeats=4, requester 1 holds last_i=0, requester 2 also requesting → 4 beats granted to 1. err_o high for 1 cycle afterwards, and the next grant goes to requester 2.
- Reset mid-burst: assert rst_ni low while in ArbLocked on requester 2 → state ArbIdle, ptr=0 and err_o=0 immediately. After release with req_i=4'b0101 → gnt_o=0001.
